// File: rtl/dot_product_pkg.sv
// Shared types and constants for the dot-product MAC pipeline.
// Holds the FSM state enum, product width and stage limits, and saturation limit helpers.
package dot_product_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } mac_state_t;

  localparam int NUM_STAGE_MIN  = 1;
  localparam int NUM_STAGE_MAX  = 4;
  localparam int SAT_CALC_WIDTH = 256;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  // Limits are built at SAT_CALC_WIDTH and sliced down to the accumulator width by the caller.
  function automatic logic [SAT_CALC_WIDTH-1:0] sat_max(input int width, input bit is_signed);
    logic [SAT_CALC_WIDTH-1:0] one;
    one = '0;
    one[0] = 1'b1;
    if (is_signed) return (one << (width - 1)) - one;
    return (one << width) - one;
  endfunction

  function automatic logic [SAT_CALC_WIDTH-1:0] sat_min(input int width, input bit is_signed);
    logic [SAT_CALC_WIDTH-1:0] one;
    one = '0;
    one[0] = 1'b1;
    if (is_signed) return one << (width - 1);
    return '0;
  endfunction

endpackage

// File: rtl/dot_product_mul_pipe.sv
// NUM_STAGE-deep registered multiplier with valid/last side-band and clock enable.
// Stage 0 captures the product; later stages only delay it.
module dot_product_mul_pipe
  import dot_product_pkg::*;
#(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 32,
  parameter int NUM_STAGE  = 2,
  parameter int SIGNED     = 1,
  parameter int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  prod_valid,
  output logic                  prod_last,
  output logic [PROD_WIDTH-1:0] prod
);

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
    $error("dot_product_mul_pipe: NUM_STAGE out of range");
  end

  logic [PROD_WIDTH-1:0] a_ext;
  logic [PROD_WIDTH-1:0] b_ext;
  logic [PROD_WIDTH-1:0] mul_comb;
  logic [PROD_WIDTH-1:0] prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]  vld_q;
  logic [NUM_STAGE-1:0]  last_q;

  // Extending both operands to the full product width makes the low bits of a plain
  // multiply equal the signed (or unsigned) product.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[DIN0_WIDTH-1:0] = din0;
    b_ext[DIN1_WIDTH-1:0] = din1;
    for (int i = DIN0_WIDTH; i < PROD_WIDTH; i++) a_ext[i] = (SIGNED != 0) && din0[DIN0_WIDTH-1];
    for (int i = DIN1_WIDTH; i < PROD_WIDTH; i++) b_ext[i] = (SIGNED != 0) && din1[DIN1_WIDTH-1];
    mul_comb = a_ext * b_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
    end else if (ce) begin
      prod_q[0] <= mul_comb;
      vld_q[0]  <= in_valid;
      last_q[0] <= in_valid & in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i] <= prod_q[i-1];
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  assign prod       = prod_q[NUM_STAGE-1];
  assign prod_valid = vld_q[NUM_STAGE-1];
  assign prod_last  = last_q[NUM_STAGE-1];

endmodule

// File: rtl/dot_product_mac_pipe.sv
// Pipelined multiply-accumulate: one dot-product result per in_last-framed vector.
// Build option DOT_PRODUCT_MAC_SAT_EN selects saturating accumulate with a sticky out_ovf.
//
//   state | meaning
//   IDLE  | accumulator empty; next product loads acc (emits at once if also last)
//   ACCUM | vector in progress; products add into acc, last emits and returns to IDLE
module dot_product_mac_pipe
  import dot_product_pkg::*;
#(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int NUM_STAGE  = 2,
  parameter int SIGNED     = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic [CNT_WIDTH-1:0]  dout_len,
  output logic                  out_ovf
);

  localparam int PROD_WIDTH = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  if (ACC_WIDTH < PROD_WIDTH) begin : g_bad_acc
    $error("dot_product_mac_pipe: ACC_WIDTH smaller than product width");
  end

  logic                  pipe_valid;
  logic                  pipe_last;
  logic [PROD_WIDTH-1:0] pipe_prod;

  dot_product_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .NUM_STAGE  (NUM_STAGE),
    .SIGNED     (SIGNED),
    .PROD_WIDTH (PROD_WIDTH)
  ) u_mul_pipe (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .din0       (din0),
    .din1       (din1),
    .prod_valid (pipe_valid),
    .prod_last  (pipe_last),
    .prod       (pipe_prod)
  );

  mac_state_t           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] sum_val;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 emit;
  logic                 clip;

  always_comb begin
    prod_ext = '0;
    prod_ext[PROD_WIDTH-1:0] = pipe_prod;
    for (int i = PROD_WIDTH; i < ACC_WIDTH; i++) prod_ext[i] = (SIGNED != 0) && pipe_prod[PROD_WIDTH-1];
  end

`ifdef DOT_PRODUCT_MAC_SAT_EN
  localparam logic [SAT_CALC_WIDTH-1:0] SAT_MAX_FULL = sat_max(ACC_WIDTH, SIGNED != 0);
  localparam logic [SAT_CALC_WIDTH-1:0] SAT_MIN_FULL = sat_min(ACC_WIDTH, SIGNED != 0);
  localparam logic [ACC_WIDTH-1:0]      SAT_MAX      = SAT_MAX_FULL[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0]      SAT_MIN      = SAT_MIN_FULL[ACC_WIDTH-1:0];

  logic [ACC_WIDTH:0] sum_ext;

  // Signed clip: operands agree in sign but the sum does not. Unsigned clip: carry out.
  always_comb begin
    base    = (state_q == ACCUM) ? acc_q : '0;
    sum_ext = {1'b0, base} + {1'b0, prod_ext};
    sum_val = sum_ext[ACC_WIDTH-1:0];
    clip    = 1'b0;
    if (SIGNED != 0) begin
      if ((base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
          (sum_ext[ACC_WIDTH-1] != base[ACC_WIDTH-1])) begin
        clip    = 1'b1;
        sum_val = base[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
    end else if (sum_ext[ACC_WIDTH]) begin
      clip    = 1'b1;
      sum_val = SAT_MAX;
    end
  end
`else
  always_comb begin
    base    = (state_q == ACCUM) ? acc_q : '0;
    sum_val = base + prod_ext;
    clip    = 1'b0;
  end
`endif

  always_comb begin
    cnt_inc = CNT_WIDTH'(1);
    if (state_q == ACCUM) cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    if (pipe_valid) begin
      if (pipe_last) begin
        emit    = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        acc_d   = sum_val;
        cnt_d   = cnt_inc;
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      dout_len  <= '0;
    end else if (ce) begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_valid <= emit;
      if (emit) begin
        dout     <= sum_val;
        dout_len <= cnt_inc;
      end
    end
  end

`ifdef DOT_PRODUCT_MAC_SAT_EN
  logic ovf_q;

  // Sticky clip flag for the vector in flight; reported alongside the result, then cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q   <= 1'b0;
      out_ovf <= 1'b0;
    end else if (ce && pipe_valid) begin
      if (emit) begin
        out_ovf <= ovf_q | clip;
        ovf_q   <= 1'b0;
      end else begin
        ovf_q <= ovf_q | clip;
      end
    end
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_mac_pipe.sv
// Directed-vector bench for dot_product_mac_pipe: default instance plus an unsigned,
// four-stage instance with a narrow counter.
module tb_dot_product_mac_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid, in_last;
  logic [31:0] din0, din1;
  logic        out_valid;
  logic [63:0] dout;
  logic [15:0] dout_len;
  logic        out_ovf;

  logic        in_valid2, in_last2;
  logic [31:0] din0_2, din1_2;
  logic        out_valid2;
  logic [63:0] dout2;
  logic [1:0]  dout_len2;
  logic        out_ovf2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dot_product_mac_pipe u_dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .din0(din0), .din1(din1), .out_valid(out_valid), .dout(dout),
    .dout_len(dout_len), .out_ovf(out_ovf)
  );

  dot_product_mac_pipe #(.NUM_STAGE(4), .SIGNED(0), .CNT_WIDTH(2)) u_dut_u (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid2), .in_last(in_last2),
    .din0(din0_2), .din1(din1_2), .out_valid(out_valid2), .dout(dout2),
    .dout_len(dout_len2), .out_ovf(out_ovf2)
  );

  // Pulse monitor for the default instance: one entry per ce-enabled out_valid cycle.
  int          cyc = 0;
  logic        ce_s = 1'b0;
  logic [63:0] q_dout[$];
  logic [15:0] q_len[$];
  logic        q_ovf[$];
  int          q_cyc[$];

  always @(posedge clk) begin
    cyc++;
    ce_s = ce;
  end

  always @(negedge clk) begin
    if (!reset && ce_s && out_valid) begin
      q_dout.push_back(dout);
      q_len.push_back(dout_len);
      q_ovf.push_back(out_ovf);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_q();
    q_dout.delete(); q_len.delete(); q_ovf.delete(); q_cyc.delete();
  endtask

  task automatic beat(input logic v, input logic l, input logic [31:0] a, input logic [31:0] b);
    in_valid = v; in_last = l; din0 = a; din1 = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1;
    in_valid = 0; in_last = 0; din0 = 0; din1 = 0;
    in_valid2 = 0; in_last2 = 0; din0_2 = 0; din1_2 = 0;
    #12;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (dout !== 64'd0) begin n_err++; $display("FAIL reset_dout: got %h want 0", dout); end
    n_vec++; if (dout_len !== 16'd0) begin n_err++; $display("FAIL reset_dout_len: got %0d want 0", dout_len); end
    n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
    n_vec++; if (out_valid2 !== 1'b0 || dout2 !== 64'd0) begin n_err++; $display("FAIL reset_u2: got v=%b d=%h want 0/0", out_valid2, dout2); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int lat;
    clear_q();
    beat(1, 0, 3, 2);
    beat(1, 0, -4, 6);
    in_valid = 1; in_last = 1; din0 = 5; din1 = -1;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      lat++;
      in_valid = 0; in_last = 0;
      if (out_valid) break;
    end
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL latency_default: got %0d want 3", lat); end
    n_vec++; if (dout !== 64'hFFFF_FFFF_FFFF_FFE9) begin n_err++; $display("FAIL dot3_dout: got %h want ffffffffffffffe9", dout); end
    n_vec++; if (dout_len !== 16'd3) begin n_err++; $display("FAIL dot3_len: got %0d want 3", dout_len); end
    n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL dot3_ovf: got %b want 0", out_ovf); end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dot3_pulse_width: got %b want 0", out_valid); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    clear_q();
    beat(1, 1, 7, -9);
    beat(1, 0, 1, 2);
    beat(1, 1, 1, 3);
    idle(6);
    n_vec++; if (q_dout.size() !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", q_dout.size()); end
    if (q_dout.size() >= 2) begin
      n_vec++; if (q_dout[0] !== 64'hFFFF_FFFF_FFFF_FFC1) begin n_err++; $display("FAIL b2b_single_dout: got %h want ffffffffffffffc1", q_dout[0]); end
      n_vec++; if (q_len[0] !== 16'd1) begin n_err++; $display("FAIL b2b_single_len: got %0d want 1", q_len[0]); end
      n_vec++; if (q_dout[1] !== 64'd5) begin n_err++; $display("FAIL b2b_pair_dout: got %h want 5", q_dout[1]); end
      n_vec++; if (q_len[1] !== 16'd2) begin n_err++; $display("FAIL b2b_pair_len: got %0d want 2", q_len[1]); end
      n_vec++; if (q_cyc[1] - q_cyc[0] !== 2) begin n_err++; $display("FAIL b2b_spacing: got %0d want 2", q_cyc[1] - q_cyc[0]); end
    end
  endtask

  task automatic test_ce_toggle();
    logic found, tog;
    clear_q();
    for (int i = 0; i < 4; i++) begin
      ce = 1'b1;
      beat(1, (i == 3), 1, 1);
      ce = 1'b0; in_valid = 0; in_last = 0;
      @(posedge clk); #1;
    end
    found = 0; tog = 1;
    for (int k = 0; k < 20; k++) begin
      ce = tog;
      @(posedge clk); #1;
      tog = ~tog;
      if (out_valid) begin found = 1; break; end
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL ce_found: got %b want 1", found); end
    n_vec++; if (dout !== 64'd4) begin n_err++; $display("FAIL ce_dout: got %h want 4", dout); end
    n_vec++; if (dout_len !== 16'd4) begin n_err++; $display("FAIL ce_len: got %0d want 4", dout_len); end
    ce = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ce_hold_valid: got %b want 1", out_valid); end
    n_vec++; if (dout !== 64'd4) begin n_err++; $display("FAIL ce_hold_dout: got %h want 4", dout); end
    ce = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ce_drop_valid: got %b want 0", out_valid); end
    n_vec++; if (q_dout.size() !== 1) begin n_err++; $display("FAIL ce_pulse_count: got %0d want 1", q_dout.size()); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    clear_q();
    beat(1, 0, 1, 1);
    beat(1, 0, 1, 1);
    in_valid = 1; in_last = 0; din0 = 1; din1 = 1;
    #3 reset = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    n_vec++; if (dout !== 64'd0) begin n_err++; $display("FAIL rst_mid_dout: got %h want 0", dout); end
    n_vec++; if (dout_len !== 16'd0) begin n_err++; $display("FAIL rst_mid_len: got %0d want 0", dout_len); end
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 0; in_last = 1;
    @(posedge clk); #1;
    beat(1, 1, 2, 2);
    idle(6);
    n_vec++; if (q_dout.size() !== 1) begin n_err++; $display("FAIL rst_mid_pulses: got %0d want 1", q_dout.size()); end
    if (q_dout.size() >= 1) begin
      n_vec++; if (q_dout[0] !== 64'd4) begin n_err++; $display("FAIL rst_mid_dout_after: got %h want 4", q_dout[0]); end
      n_vec++; if (q_len[0] !== 16'd1) begin n_err++; $display("FAIL rst_mid_len_after: got %0d want 1", q_len[0]); end
    end
  endtask

  task automatic test_wrap_sat();
    logic [63:0] exp_d[3];
    logic        exp_o[3];
    logic [15:0] exp_l[3];
`ifdef DOT_PRODUCT_MAC_SAT_EN
    exp_d[0] = 64'h7FFF_FFFF_FFFF_FFFF; exp_o[0] = 1'b1;
    exp_d[1] = 64'h8000_0000_0000_0000; exp_o[1] = 1'b1;
`else
    exp_d[0] = 64'hBFFF_FFFD_0000_0003; exp_o[0] = 1'b0;
    exp_d[1] = 64'h4000_0001_8000_0000; exp_o[1] = 1'b0;
`endif
    exp_d[2] = 64'd1; exp_o[2] = 1'b0;
    exp_l[0] = 16'd3; exp_l[1] = 16'd3; exp_l[2] = 16'd1;
    clear_q();
    for (int i = 0; i < 3; i++) beat(1, (i == 2), 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    for (int i = 0; i < 3; i++) beat(1, (i == 2), 32'h8000_0000, 32'h7FFF_FFFF);
    beat(1, 1, 1, 1);
    idle(6);
    n_vec++; if (q_dout.size() !== 3) begin n_err++; $display("FAIL wide_count: got %0d want 3", q_dout.size()); end
    if (q_dout.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (q_dout[i] !== exp_d[i]) begin n_err++; $display("FAIL wide_dout[%0d]: got %h want %h", i, q_dout[i], exp_d[i]); end
        n_vec++; if (q_ovf[i] !== exp_o[i]) begin n_err++; $display("FAIL wide_ovf[%0d]: got %b want %b", i, q_ovf[i], exp_o[i]); end
        n_vec++; if (q_len[i] !== exp_l[i]) begin n_err++; $display("FAIL wide_len[%0d]: got %0d want %0d", i, q_len[i], exp_l[i]); end
      end
    end
  endtask

  task automatic test_unsigned_deep();
    int lat;
    logic found;
    in_valid2 = 1; in_last2 = 1; din0_2 = 32'hFFFF_FFFF; din1_2 = 32'd2;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      lat++;
      in_valid2 = 0; in_last2 = 0;
      if (out_valid2) break;
    end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL u_latency: got %0d want 5", lat); end
    n_vec++; if (dout2 !== 64'h1_FFFF_FFFE) begin n_err++; $display("FAIL u_dout: got %h want 1fffffffe", dout2); end
    n_vec++; if (dout_len2 !== 2'd1) begin n_err++; $display("FAIL u_len: got %0d want 1", dout_len2); end
    n_vec++; if (out_ovf2 !== 1'b0) begin n_err++; $display("FAIL u_ovf: got %b want 0", out_ovf2); end
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1; in_last2 = (i == 4); din0_2 = 1; din1_2 = 1;
      @(posedge clk); #1;
    end
    in_valid2 = 0; in_last2 = 0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid2) begin found = 1; break; end
      @(posedge clk); #1;
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL u_cnt_found: got %b want 1", found); end
    n_vec++; if (dout2 !== 64'd5) begin n_err++; $display("FAIL u_cnt_dout: got %h want 5", dout2); end
    n_vec++; if (dout_len2 !== 2'd3) begin n_err++; $display("FAIL u_cnt_len_sat: got %0d want 3", dout_len2); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_ce_toggle();
    test_reset_mid();
    test_wrap_sat();
    test_unsigned_deep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
